// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared fixed-point constants and helpers
//
// Purpose: rounding-mode codes, word-width helper and the bit patterns of the
// largest and smallest representable signed values for a given width.
// Ports: none (package).
package fxp_pkg;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;

  function automatic int fxp_width(input int int_bits, input int frac_bits);
    return int_bits + frac_bits;
  endfunction

  // Bit pattern of the most positive w-bit two's-complement value (low w bits).
  function automatic logic [63:0] fxp_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative w-bit two's-complement value (low w bits).
  function automatic logic [63:0] fxp_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// rtl/fxp_round_sat.sv - rescale a double-width product to Q(INT).(FRAC) with round/saturate
//
// Purpose: takes a 2W-bit signed product carrying 2*FRAC_BITS fraction bits,
// optionally rounds half-up, shifts back to FRAC_BITS fraction bits and either
// clamps or wraps on overflow. Purely combinational.
// Ports:
//   full  in  2W  signed product
//   p     out W   rescaled result
//   ovf   out 1   result did not fit in W bits
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int INT_BITS  = 17,
  parameter int FRAC_BITS = 15,
  parameter int ROUND     = RND_HALF_UP,
  parameter int SAT       = 1
) (
  input  logic [2*fxp_width(INT_BITS, FRAC_BITS)-1:0] full,
  output logic [fxp_width(INT_BITS, FRAC_BITS)-1:0]   p,
  output logic                                        ovf
);

  localparam int W  = fxp_width(INT_BITS, FRAC_BITS);
  localparam int RW = 2 * W + 1;

  localparam logic [63:0]  MAX64 = fxp_max(W);
  localparam logic [63:0]  MIN64 = fxp_min(W);
  localparam logic [W-1:0] PMAX  = MAX64[W-1:0];
  localparam logic [W-1:0] PMIN  = MIN64[W-1:0];

  // Half an LSB of the output format; the guard on the shift keeps the
  // expression legal when there are no fraction bits.
  localparam logic [RW-1:0] RND_ADD =
    (ROUND == RND_HALF_UP && FRAC_BITS > 0) ?
    (RW'(1) << (FRAC_BITS > 0 ? FRAC_BITS - 1 : 0)) : '0;

  logic signed [RW-1:0] r;
  logic signed [RW-1:0] q;

  always_comb begin
    // One extra bit so the rounding add can never wrap.
    r   = {full[2*W-1], full} + RND_ADD;
    q   = r >>> FRAC_BITS;
    // Fits only if every bit from W-1 upward is a copy of the sign.
    ovf = !((&q[RW-1:W-1]) || !(|q[RW-1:W-1]));
    if (ovf && SAT != 0) begin
      p = q[RW-1] ? PMIN : PMAX;
    end else begin
      p = q[W-1:0];
    end
  end

endmodule

// File: rtl/fxp_mult_pipe.sv
// rtl/fxp_mult_pipe.sv - pipelined signed fixed-point multiplier with valid/ready
//
// Purpose: p = a*b in Q(INT_BITS).(FRAC_BITS), latency STAGES (2..6), one
// sample per cycle, whole pipeline stalls on back-pressure.
// Stage 1 registers operands, stages 2..STAGES-1 hold the full product
// (extra stages only balance), the last stage holds the rounded result.
// Ports:
//   clk        in  1  clock, rising edge
//   rst        in  1  asynchronous active-high reset
//   in_valid   in  1  a/b valid
//   in_ready   out 1  operands accepted this cycle
//   a, b       in  W  signed operands
//   out_valid  out 1  p/ovf valid
//   out_ready  in  1  consumer takes the result
//   p          out W  signed product
//   ovf        out 1  this sample overflowed
module fxp_mult_pipe
  import fxp_pkg::*;
#(
  parameter int INT_BITS  = 17,
  parameter int FRAC_BITS = 15,
  parameter int STAGES    = 3,
  parameter int ROUND     = RND_HALF_UP,
  parameter int SAT       = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [fxp_width(INT_BITS, FRAC_BITS)-1:0] a,
  input  logic [fxp_width(INT_BITS, FRAC_BITS)-1:0] b,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [fxp_width(INT_BITS, FRAC_BITS)-1:0] p,
  output logic                                      ovf
);

  localparam int W   = fxp_width(INT_BITS, FRAC_BITS);
  localparam int PW  = 2 * W;
  localparam int MID = STAGES - 2;  // number of product-holding stages

  logic              en;
  logic [STAGES-1:0] vld;
  logic signed [W-1:0]  a_r;
  logic signed [W-1:0]  b_r;
  logic signed [PW-1:0] full;
  logic [W-1:0]      p_n;
  logic              ovf_n;
  logic [W-1:0]      p_r;
  logic              ovf_r;

  // A single enable for every stage: the pipe moves unless a finished
  // result is waiting on the consumer. Bubbles move too, never collapse.
  assign en        = !vld[STAGES-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld[STAGES-1];
  assign p         = p_r;
  assign ovf       = ovf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (en) begin
      vld <= {vld[STAGES-2:0], in_valid};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
    end else if (en) begin
      a_r <= a;
      b_r <= b;
    end
  end

  generate
    if (MID == 0) begin : g_comb_prod
      // Two-stage build: multiply feeds the output stage directly.
      assign full = PW'(a_r) * PW'(b_r);
    end else begin : g_pipe_prod
      logic signed [PW-1:0] prod [MID];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < MID; i++) begin
            prod[i] <= '0;
          end
        end else if (en) begin
          prod[0] <= PW'(a_r) * PW'(b_r);
          for (int i = 1; i < MID; i++) begin
            prod[i] <= prod[i-1];
          end
        end
      end

      assign full = prod[MID-1];
    end
  endgenerate

  fxp_round_sat #(
    .INT_BITS  (INT_BITS),
    .FRAC_BITS (FRAC_BITS),
    .ROUND     (ROUND),
    .SAT       (SAT)
  ) u_round_sat (
    .full (full),
    .p    (p_n),
    .ovf  (ovf_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r   <= '0;
      ovf_r <= 1'b0;
    end else if (en) begin
      p_r   <= p_n;
      ovf_r <= ovf_n;
    end
  end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb/tb_fxp_mult_pipe.sv - directed bench for fxp_mult_pipe (round/sat and trunc/wrap builds)
module tb_fxp_mult_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p1;  // ROUND=1, SAT=1
    logic        o1;
    logic [31:0] p2;  // ROUND=0, SAT=0
    logic        o2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        ovf;
  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] p2;
  logic        ovf2;

  int          checks   = 0;
  int          failures = 0;
  int          out_cnt  = 0;
  int          cnt_mark;
  int          wt;
  logic [31:0] held_p;
  vec_t        vt [10];
  vec_t        exp_q [$];
  vec_t        mon_e;

  always #5 clk = ~clk;

  fxp_mult_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .ovf       (ovf)
  );

  fxp_mult_pipe #(.ROUND(0), .SAT(0)) dut_tw (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .a         (a),
    .b         (b),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .p         (p2),
    .ovf       (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents vector i until accepted; expectation is queued just before the
  // accepting edge.
  task automatic send(input int i);
    bit acc = 1'b0;
    a        = vt[i].a;
    b        = vt[i].b;
    in_valid = 1'b1;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(vt[i]);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("p_rs", p, mon_e.p1);
        check("ovf_rs", {31'd0, ovf}, {31'd0, mon_e.o1});
        check("p_tw", p2, mon_e.p2);
        check("ovf_tw", {31'd0, ovf2}, {31'd0, mon_e.o2});
        check("valid_tw", {31'd0, out_valid2}, 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    //          a             b             p1            o1    p2            o2
    vt[0] = '{32'h0001_0000, 32'h0002_8000, 32'h0005_0000, 1'b0, 32'h0005_0000, 1'b0};
    vt[1] = '{32'hFFFF_4000, 32'h0001_0000, 32'hFFFE_8000, 1'b0, 32'hFFFE_8000, 1'b0};
    vt[2] = '{32'h0080_0000, 32'h0080_0000, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1};
    vt[3] = '{32'hFF00_0000, 32'h0080_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vt[4] = '{32'hFF80_0000, 32'h0080_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0};
    vt[5] = '{32'h0000_0001, 32'h0000_4000, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0};
    vt[6] = '{32'hFFFF_FFFF, 32'h0000_4000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vt[7] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1};
    vt[8] = '{32'h4000_4000, 32'h0000_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0};
    vt[9] = '{32'h7FFF_FFFF, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_p", p, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: result visible after the third edge counting the accept edge.
    send(0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("lat_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_exact", {31'd0, out_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    for (int i = 1; i < 10; i++) send(i);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("stream_drain", exp_q.size(), 32'd0);
    check("stream_count", out_cnt, 32'd10);

    // Back-pressure: 6 back-to-back samples, 4-cycle stall on first result.
    cnt_mark = out_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send(i);
        in_valid = 1'b0;
      end
      begin
        wt = 0;
        while (!out_valid && wt < 20) begin
          @(posedge clk);
          #1;
          wt++;
        end
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        held_p    = p;
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_hold_p", p, held_p);
          check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check("bp_drain", exp_q.size(), 32'd0);
    check("bp_count", out_cnt - cnt_mark, 32'd6);

    // Asynchronous reset with three samples in flight.
    send(0);
    send(1);
    send(2);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_p", p, 32'd0);
    check("arst_ovf", {31'd0, ovf}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fxp_mult_pipe.md
Name: fxp_mult_pipe

Overview:
- Parametrised, pipelined, signed fixed-point multiplier with valid/ready handshake, selectable rounding and saturation, and an overflow flag.
- Successor to the single-format `mult` core used by the pseudoinverse datapath. Default format is Q17.15, 32 bits.
- Feeds the matrix-product and normalisation stages, which need back-pressure and a defined overflow behaviour.

Parameters:
- INT_BITS, 17, integer bits including sign.
- FRAC_BITS, 15, fraction bits. W = INT_BITS+FRAC_BITS.
- STAGES, 3, pipeline depth, legal range 2..6. Latency equals STAGES.
- ROUND, 1, 0 = truncate toward -inf, 1 = round-half-up.
- SAT, 1, 1 = clamp on overflow, 0 = wrap (keep low bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  W  signed multiplicand, Q(INT_BITS).(FRAC_BITS).
- b  in  W  signed multiplier, same format.
- out_valid  out  1  p/ovf valid.
- out_ready  in  1  consumer accepts the result.
- p  out  W  signed product, same format.
- ovf  out  1  result exceeded the range; sticky per sample, not accumulated.

Behaviour:
- Reset (async, rst=1): all stage valid bits=0, out_valid=0, p=0, ovf=0. in_ready=1 once out_valid=0. Data registers may stay undefined internally but p must read 0. In-flight samples are discarded. The first accepted sample after rst deasserts appears STAGES cycles later.
- Handshake:
  - en = !out_valid | out_ready.
  - in_ready = en.
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - When en=0 every stage holds, data and valid.
  - p/ovf stay stable while out_valid=1 and out_ready=0.
- Throughput is one sample per cycle with out_ready held high. Pipeline bubbles (in_valid=0) propagate as valid=0 and are not collapsed.
- Stage 1 registers a and b. Stages 2..STAGES-1 form the full 2W-bit signed product, with any extra stages as balancing registers. The final stage registers the rounded/saturated result.
- Arithmetic:
  - full = a*b, signed, 2W bits, with FRAC_BITS*2 fraction bits.
  - ROUND=1 and FRAC_BITS>0: r = full + 2^(FRAC_BITS-1), computed in 2W+1 bits. Otherwise r = full.
  - q = r >>> FRAC_BITS (arithmetic).
  - Overflow when the bits of q above W-1 are not all equal to q[W-1].
- Saturation:
  - SAT=1: positive overflow gives p = 2^(W-1)-1; negative overflow gives p = -2^(W-1).
  - SAT=0: p = q[W-1:0].
  - ovf=1 whenever overflow is detected, regardless of SAT.
- Boundaries:
  - The most negative operand times the most negative operand must saturate positive.
  - Rounding that carries past the maximum value counts as overflow.
  - Simultaneous accept and emit in the same cycle is legal and loses no data.

Decomposition:
- Package fxp_pkg:
  - rounding-mode constants RND_TRUNC=0, RND_HALF_UP=1;
  - function fxp_width(INT_BITS, FRAC_BITS);
  - max/min constant helpers.
- Sub-module fxp_round_sat: combinational; takes the 2W-bit product and outputs W-bit p plus ovf. It is parametrised by INT_BITS, FRAC_BITS, ROUND and SAT, and is reusable by the adder/accumulator blocks.

Test Plan:
- Default params, out_ready=1: a=0x0001_0000 (2.0), b=0x0002_8000 (5.0) -> p=0x0005_0000, ovf=0, exactly 3 cycles after acceptance.
- a=0xFFFF_4000 (-1.5), b=0x0001_0000 (2.0) -> p=0xFFFE_8000 (-3.0), ovf=0.
- Saturation:
  - a=b=0x0080_0000 (256*256) -> p=0x7FFF_FFFF, ovf=1.
  - a=0xFF00_0000 (-512), b=0x0080_0000 (256) -> p=0x8000_0000, ovf=1.
  - a=0xFF80_0000 (-256), b=0x0080_0000 -> p=0x8000_0000, ovf=0 (exact min).
- Rounding: a=0x0000_0001, b=0x0000_4000 -> p=0x0000_0001 with ROUND=1 and p=0 with ROUND=0. a=0xFFFF_FFFF, b=0x0000_4000 -> p=0 with ROUND=1, 0xFFFF_FFFF with ROUND=0.
- Back-pressure: stream 6 back-to-back samples; drop out_ready for 4 cycles once the first result is valid. Required: in_ready=0 during the stall, p held stable, all 6 results delivered in order with no duplicates or loss.
- Reset mid-operation: assert rst asynchronously with 3 samples in flight. Required: out_valid=0 and p=0 immediately (before the next clk edge), and no stale result appears after release.
